imem_block_responder: RTL and testbench
=======================================

Name: imem_block_responder

Overview:
- Responder end of the instruction-fetch block-refill interface.
- Sits behind the instruction cache controller. It accepts a 6-bit block address with a level read request, holds busywait for a programmable number of cycles, then returns a 128-bit (16-byte) block.
- Backing store is a 256-byte array, loaded through a byte preload port by the bench or boot logic.

Parameters:
- LATENCY, 5: cycles spent in BUSY before data returns; legal range 1..255.
- BLOCK_AW, 6: block address width (64 blocks).
- BLOCK_BYTES, 16: bytes per block (128-bit readdata).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- read  in  1  level request from the cache; held high until busywait falls.
- address  in  6  block address; latched when a request is accepted.
- readdata  out  128  returned block; byte 0 of the block is in [7:0] (little-endian).
- busywait  out  1  high while a request is outstanding.
- load_en  in  1  preload byte write strobe.
- load_addr  in  8  preload byte address.
- load_data  in  8  preload byte.
- load_err  out  1  one-cycle pulse when a preload is rejected.
- access_count  out  16  completed block reads; saturates at 16'hFFFF.

Behaviour:
- Reset, clk and reset: reset is synchronous, active-high; clock is clk.
  - On reset: state=IDLE, cnt=0, readdata=128'h0, load_err=0, access_count=0, latched address=0. busywait follows its equation, so it is 0 unless read is high.
  - Storage array is NOT cleared by reset.
- States: IDLE, BUSY, DONE (2-bit encoding).
- busywait is combinational: (state==IDLE && read) || state==BUSY. It rises in the same cycle read rises, so the cache stalls without a one-cycle gap. It is 0 in DONE.
- IDLE:
  - read high at an edge: latch address, cnt=LATENCY-1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - read low at an edge: abort. Go to IDLE; readdata and access_count unchanged.
  - Else if cnt==0: go to DONE. readdata <= bytes {lat_addr,4'hF}..{lat_addr,4'h0}; access_count += 1 (saturating).
  - Else cnt -= 1.
- Latency: read first sampled at edge k. DONE is entered and readdata is valid at edge k+LATENCY; busywait falls from that edge.
- DONE:
  - Unconditionally go to IDLE at the next edge. readdata holds its value until the next completed read.
  - If read is still high on return to IDLE, a new access starts. This is legal, and the address is re-latched.
- address changes while BUSY are ignored; the latched address is used.
- Preload:
  - Accepted only when state==IDLE and read==0: mem[load_addr] <= load_data at the edge.
  - Otherwise the write is dropped and load_err=1 for that cycle only.
  - An accepted write is visible to a read accepted at the next edge or later.
- Reset asserted in BUSY or DONE aborts the transfer. The next cycle is IDLE with all outputs at reset values.
- No X on readdata after reset. Storage bytes are X until preloaded; that is legal.

Decomposition:
- Shared package imem_pkg: state typedef (IDLE/BUSY/DONE), BLOCK_AW, BLOCK_BYTES, default LATENCY, and byte-address construction {block,offset}.
- One sub-module, imem_byte_array:
  - 256x8 storage.
  - One write port (we, waddr, wdata).
  - A combinational 16-byte block read port indexed by block address.
- The FSM, counter, preload arbitration and access counter stay in the top module.

Test Plan:
1. Nominal read:
   - Stimulus: preload bytes 0x10..0x1F with 0x00..0x0F, LATENCY=5, read=1, address=1 at edge 0.
   - Response: busywait high in cycles 0-4; at edge 5 readdata=128'h0F0E0D0C0B0A09080706050403020100, busywait=0; access_count=1.
2. LATENCY=1:
   - Stimulus: read block 63 preloaded with 0xA5 in every byte.
   - Response: data 128'hA5A5...A5 at edge 1; busywait high for exactly one cycle.
3. Abort:
   - Stimulus: read=1 at edge 0, read=0 at edge 2.
   - Response: IDLE at edge 2, busywait=0, readdata unchanged, access_count unchanged.
4. Preload during a transfer:
   - Stimulus: load_en=1 in BUSY targeting the block being fetched.
   - Response: load_err pulses for that cycle; returned data equals pre-write contents.
5. Back-to-back reads:
   - Stimulus: hold read high through DONE; address changes from 2 to 3 during BUSY, and 3 is still presented at DONE.
   - Response: first return is block 2; a new access for block 3 is accepted at the IDLE edge; access_count ends at 2.
6. Reset mid-transfer:
   - Stimulus: reset at edge 3 of a LATENCY=5 read.
   - Response: IDLE, readdata=0, access_count=0.
   - Follow-up: a later read returns the preloaded contents intact.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction block responder
package imem_pkg;

   localparam int BLOCK_AW        = 6;
   localparam int BLOCK_BYTES     = 16;
   localparam int OFFSET_W        = 4;
   localparam int MEM_AW          = 8;
   localparam int MEM_BYTES       = 1 << MEM_AW;
   localparam int DEFAULT_LATENCY = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // The backing store holds only 16 blocks. The upper block-address bits
   // therefore alias, so block 63 shares storage with block 15 (bytes F0..FF).
   function automatic logic [MEM_AW-1:0] byte_addr(input logic [BLOCK_AW-1:0] blk,
                                                   input logic [OFFSET_W-1:0] off);
      return {blk[MEM_AW-OFFSET_W-1:0], off};
   endfunction

endpackage

// File: rtl/imem_block_responder_if.sv
// rtl/imem_block_responder_if.sv - instruction block refill handshake between cache and responder
interface imem_block_responder_if;
   import imem_pkg::*;

   logic                       read;
   logic [BLOCK_AW-1:0]        address;
   logic [BLOCK_BYTES*8-1:0]   readdata;
   logic                       busywait;

   modport master (
      output read,
      output address,
      input  readdata,
      input  busywait
   );

   modport slave (
      input  read,
      input  address,
      output readdata,
      output busywait
   );

endinterface

// File: rtl/imem_byte_array.sv
// rtl/imem_byte_array.sv - 256x8 byte store with a byte write port and a whole-block read port
module imem_byte_array
   import imem_pkg::*;
(
   input  logic                     clk,
   input  logic                     we,
   input  logic [MEM_AW-1:0]        waddr,
   input  logic [7:0]               wdata,
   input  logic [BLOCK_AW-1:0]      rblock,
   output logic [BLOCK_BYTES*8-1:0] rdata
);

   logic [7:0] mem [0:MEM_BYTES-1];

   // Byte write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Assemble the addressed block little-endian: byte 0 lands in [7:0].
   always_comb begin
      rdata = '0;
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         rdata[8*i +: 8] = mem[byte_addr(rblock, OFFSET_W'(i))];
      end
   end

endmodule

// File: rtl/imem_block_responder.sv
// rtl/imem_block_responder.sv - responder for instruction-cache block refills with programmable latency
module imem_block_responder
   import imem_pkg::*;
#(
   // Cycles spent in BUSY before data returns; legal range 1..255.
   parameter int LATENCY = DEFAULT_LATENCY
)
(
   input  logic                  clk,
   input  logic                  reset,
   imem_block_responder_if.slave bus,
   input  logic                  load_en,
   input  logic [MEM_AW-1:0]     load_addr,
   input  logic [7:0]            load_data,
   output logic                  load_err,
   output logic [15:0]           access_count
);

   localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

   state_t                   state;
   logic [7:0]               cnt;
   logic [BLOCK_AW-1:0]      lat_addr;
   logic [BLOCK_BYTES*8-1:0] block_data;
   logic                     load_ok;

   // Preloads only land while the responder is idle and no request is pending,
   // so a fetch never observes a half-updated block.
   assign load_ok = load_en && (state == IDLE) && !bus.read;

   // Combinational so the cache stalls in the very cycle it raises read.
   assign bus.busywait = ((state == IDLE) && bus.read) || (state == BUSY);

   imem_byte_array u_array (
      .clk    (clk),
      .we     (load_ok),
      .waddr  (load_addr),
      .wdata  (load_data),
      .rblock (lat_addr),
      .rdata  (block_data)
   );

   // Request FSM: accept, count down the latency, return the block, and track preload rejects.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         lat_addr     <= '0;
         bus.readdata <= '0;
         load_err     <= 1'b0;
         access_count <= 16'd0;
      end else begin
         load_err <= load_en && !load_ok;
         case (state)
            IDLE: begin
               if (bus.read) begin
                  lat_addr <= bus.address;
                  cnt      <= CNT_INIT;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (!bus.read) begin
                  state <= IDLE;
               end else if (cnt == 8'd0) begin
                  state        <= DONE;
                  bus.readdata <= block_data;
                  if (access_count != 16'hFFFF) begin
                     access_count <= access_count + 16'd1;
                  end
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_block_responder.sv
// tb/tb_imem_block_responder.sv - scoreboard bench for imem_block_responder
module tb_imem_block_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [7:0]  load_data;
   logic        load_err5, load_err1;
   logic [15:0] ac5, ac1;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0]   mdl [256];
   logic [127:0] q5 [$];
   logic [127:0] q1 [$];
   logic [15:0]  prev5 = 16'd0;
   logic [15:0]  prev1 = 16'd0;

   always #5 clk = ~clk;

   imem_block_responder_if bus5 ();
   imem_block_responder_if bus1 ();

   imem_block_responder #(.LATENCY(5)) dut5 (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus5.slave),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_err     (load_err5),
      .access_count (ac5)
   );

   imem_block_responder #(.LATENCY(1)) dut1 (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus1.slave),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_err     (load_err1),
      .access_count (ac1)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] exp_block(input logic [5:0] blk);
      logic [127:0] r;
      logic [3:0]   lo;
      lo = blk[3:0];
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = mdl[{lo, 4'(i)}];
      end
      return r;
   endfunction

   // Completion monitors: every access_count step pops one expected block.
   always @(negedge clk) begin
      if (!reset && ac5 === prev5 + 16'd1) begin
         if (q5.size() == 0) chk("spurious5", 1, 0);
         else                chk("rdata5", bus5.readdata, q5.pop_front());
      end
      prev5 = ac5;
   end

   always @(negedge clk) begin
      if (!reset && ac1 === prev1 + 16'd1) begin
         if (q1.size() == 0) chk("spurious1", 1, 0);
         else                chk("rdata1", bus1.readdata, q1.pop_front());
      end
      prev1 = ac1;
   end

   task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
      load_addr = a;
      load_data = d;
      load_en   = 1'b1;
      @(posedge clk); #1;
      load_en = 1'b0;
      chk("load_ok_err", load_err5, 0);
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   // Full read on the LATENCY=5 instance; returns with read dropped in DONE.
   task automatic run_read5(input logic [5:0] a, input int exp_lat);
      int n;
      bit done;
      q5.push_back(exp_block(a));
      bus5.address = a;
      bus5.read    = 1'b1;
      #1 chk("busy_rise5", bus5.busywait, 1);
      n = 0;
      done = 0;
      while (!done && n < 300) begin
         @(posedge clk); #1;
         n++;
         if (!bus5.busywait) done = 1;
      end
      if (!done) chk("timeout5", 0, 1);
      chk("latency5", n - 1, exp_lat);
      bus5.read = 1'b0;
   endtask

   initial begin
      int n;
      bit done;

      reset        = 1'b1;
      load_en      = 1'b0;
      load_addr    = 8'h00;
      load_data    = 8'h00;
      bus5.read    = 1'b0;
      bus5.address = 6'd0;
      bus1.read    = 1'b0;
      bus1.address = 6'd0;
      repeat (2) step();
      chk("rst_rdata5", bus5.readdata, 0);
      chk("rst_ac5", ac5, 0);
      chk("rst_busy5", bus5.busywait, 0);
      chk("rst_lerr5", load_err5, 0);
      chk("rst_rdata1", bus1.readdata, 0);
      reset = 1'b0;
      step();

      // Preload every byte; block 1 gets 00..0F, block 15/63 gets A5.
      for (int a = 0; a < 256; a++) begin
         if (a >= 8'h10 && a <= 8'h1F)  mdl[a] = 8'(a - 8'h10);
         else if (a >= 8'hF0)           mdl[a] = 8'hA5;
         else                           mdl[a] = 8'(a) ^ 8'h5A;
         load_byte(8'(a), mdl[a]);
      end
      step();

      // Nominal read of block 1.
      run_read5(6'd1, 5);
      chk("nominal_const", bus5.readdata, 128'h0F0E0D0C0B0A09080706050403020100);
      chk("nominal_ac", ac5, 1);
      step();

      // LATENCY=1 read of block 63.
      q1.push_back({16{8'hA5}});
      bus1.address = 6'd63;
      bus1.read    = 1'b1;
      n = 0;
      done = 0;
      while (!done && n < 50) begin
         @(posedge clk); #1;
         n++;
         if (!bus1.busywait) done = 1;
      end
      chk("latency1", n - 1, 1);
      chk("lat1_data", bus1.readdata, {16{8'hA5}});
      bus1.read = 1'b0;
      step();

      // Abort: read dropped before edge 2.
      bus5.address = 6'd7;
      bus5.read    = 1'b1;
      step();
      step();
      bus5.read = 1'b0;
      step();
      chk("abort_busy", bus5.busywait, 0);
      chk("abort_rdata", bus5.readdata, 128'h0F0E0D0C0B0A09080706050403020100);
      chk("abort_ac", ac5, 1);
      step();

      // Preload attempt into the block being fetched.
      q5.push_back(exp_block(6'd4));
      bus5.address = 6'd4;
      bus5.read    = 1'b1;
      step();
      load_addr = 8'h42;
      load_data = 8'hEE;
      load_en   = 1'b1;
      step();
      load_en = 1'b0;
      chk("reject_pulse", load_err5, 1);
      step();
      chk("reject_clear", load_err5, 0);
      n = 0;
      while (bus5.busywait && n < 50) begin
         step();
         n++;
      end
      bus5.read = 1'b0;
      chk("reject_ac", ac5, 2);
      step();

      // Back-to-back: address swapped during BUSY, read held through DONE.
      q5.push_back(exp_block(6'd2));
      q5.push_back(exp_block(6'd3));
      bus5.address = 6'd2;
      bus5.read    = 1'b1;
      n = 0;
      while (ac5 != 16'd4 && n < 60) begin
         step();
         n++;
         if (n == 3) bus5.address = 6'd3;
      end
      bus5.read = 1'b0;
      chk("b2b_ac", ac5, 4);
      chk("b2b_last", bus5.readdata, exp_block(6'd3));
      step();
      step();

      // Reset at edge 3 of a LATENCY=5 read.
      bus5.address = 6'd5;
      bus5.read    = 1'b1;
      step();
      step();
      step();
      reset     = 1'b1;
      bus5.read = 1'b0;
      step();
      chk("midrst_rdata", bus5.readdata, 0);
      chk("midrst_ac", ac5, 0);
      chk("midrst_busy", bus5.busywait, 0);
      chk("midrst_ac1", ac1, 0);
      reset = 1'b0;
      step();
      run_read5(6'd5, 5);
      chk("post_rst_ac", ac5, 1);
      step();
      step();

      chk("q5_drained", q5.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
